// File: rtl/wb_stage.sv
// Writeback stage: merges load and ALU results onto one register-file write port.
// ALU results that cannot write right away wait in a small FIFO.
module wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    output logic              we_,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] chk_addr_0,
    input  logic [ADDR_W-1:0] chk_addr_1,
    output logic              pend_0,
    output logic              pend_1,
    output logic [1:0]        buf_cnt
);
    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [1:0]       DEPTH_C  = 2'(DEPTH);

    logic [ADDR_W-1:0] r_buf_addr [DEPTH];
    logic [DATA_W-1:0] r_buf_data [DEPTH];
    logic [DEPTH-1:0]  r_buf_vld;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [1:0]        r_cnt;
    logic              r_we_n;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    logic              w_alu_ready;
    logic              w_alu_acc;
    logic              w_push;
    logic              w_pop;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic [DEPTH-1:0]  w_hit_0;
    logic [DEPTH-1:0]  w_hit_1;

    assign w_alu_ready = (r_cnt < DEPTH_C);
    assign w_alu_acc   = alu_valid && w_alu_ready;
    // The buffer drains only when no load claims the port; ALU bypasses only when nothing is older.
    assign w_pop       = !ld_valid && (r_cnt != 2'd0);
    assign w_push      = w_alu_acc && (ld_valid || (r_cnt != 2'd0));

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = r_wr_addr;
        w_wr_data = r_wr_data;
        if (ld_valid) begin
            w_wr_en   = 1'b1;
            w_wr_addr = ld_addr;
            w_wr_data = ld_data;
        end else if (r_cnt != 2'd0) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_buf_addr[r_head];
            w_wr_data = r_buf_data[r_head];
        end else if (w_alu_acc) begin
            w_wr_en   = 1'b1;
            w_wr_addr = alu_addr;
            w_wr_data = alu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we_n    <= 1'b1;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_we_n    <= !w_wr_en;
            r_wr_addr <= w_wr_addr;
            r_wr_data <= w_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= 2'd0;
        end else begin
            if (w_pop)
                r_head <= (r_head == PTR_LAST) ? '0 : r_head + PTR_W'(1);
            if (w_push)
                r_tail <= (r_tail == PTR_LAST) ? '0 : r_tail + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Payload needs no reset: the valid bits alone decide what is live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_addr[r_tail] <= alu_addr;
            r_buf_data[r_tail] <= alu_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (reset)
                    r_buf_vld[gi] <= 1'b0;
                else if (w_push && (r_tail == PTR_W'(gi)))
                    r_buf_vld[gi] <= 1'b1;
                else if (w_pop && (r_head == PTR_W'(gi)))
                    r_buf_vld[gi] <= 1'b0;
            end
            assign w_hit_0[gi] = r_buf_vld[gi] && (r_buf_addr[gi] == chk_addr_0);
            assign w_hit_1[gi] = r_buf_vld[gi] && (r_buf_addr[gi] == chk_addr_1);
        end
    endgenerate

    assign pend_0    = |w_hit_0;
    assign pend_1    = |w_hit_1;
    assign alu_ready = w_alu_ready;
    assign buf_cnt   = r_cnt;
    assign we_       = r_we_n;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
endmodule

// File: tb/tb_wb_stage.sv
// Directed vectors for wb_stage: each row gives one cycle's inputs, the state
// visible before the edge, and the registered write port after the edge.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        we_;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  chk_addr_0;
    logic [4:0]  chk_addr_1;
    logic        pend_0;
    logic        pend_1;
    logic [1:0]  buf_cnt;

    int n_vec = 0;
    int n_err = 0;

    wb_stage #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
        .alu_ready(alu_ready), .we_(we_), .wr_addr(wr_addr), .wr_data(wr_data),
        .chk_addr_0(chk_addr_0), .chk_addr_1(chk_addr_1),
        .pend_0(pend_0), .pend_1(pend_1), .buf_cnt(buf_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        ldv;
        logic [4:0]  lda;
        logic [31:0] ldd;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic [4:0]  c0;
        logic [4:0]  c1;
        logic [1:0]  cnt;
        logic        rdy;
        logic        p0;
        logic        p1;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic ldv, input int lda, input int ldd,
                                input logic av, input int aa, input int ad,
                                input int c0, input int c1,
                                input int cnt, input logic rdy, input logic p0, input logic p1,
                                input logic we, input int wa, input int wd);
        vec_t v;
        v.rst = rst; v.ldv = ldv; v.lda = 5'(lda); v.ldd = 32'(ldd);
        v.av = av; v.aa = 5'(aa); v.ad = 32'(ad);
        v.c0 = 5'(c0); v.c1 = 5'(c1);
        v.cnt = 2'(cnt); v.rdy = rdy; v.p0 = p0; v.p1 = p1;
        v.we = we; v.wa = 5'(wa); v.wd = 32'(wd);
        return v;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        logic [1:0] s_cnt;
        logic       s_rdy, s_p0, s_p1;
        @(negedge clk);
        reset = v.rst;
        ld_valid = v.ldv;  ld_addr = v.lda;  ld_data = v.ldd;
        alu_valid = v.av;  alu_addr = v.aa;  alu_data = v.ad;
        chk_addr_0 = v.c0; chk_addr_1 = v.c1;
        #1;
        s_cnt = buf_cnt; s_rdy = alu_ready; s_p0 = pend_0; s_p1 = pend_1;
        @(posedge clk);
        #1;
        n_vec++;
        if (s_cnt !== v.cnt || s_rdy !== v.rdy || s_p0 !== v.p0 || s_p1 !== v.p1 ||
            we_ !== v.we || wr_addr !== v.wa || wr_data !== v.wd) begin
            n_err++;
            $display("FAIL vec%0d: got cnt=%0d rdy=%b p0=%b p1=%b we_=%b wa=%0d wd=%h, want cnt=%0d rdy=%b p0=%b p1=%b we_=%b wa=%0d wd=%h",
                     idx, s_cnt, s_rdy, s_p0, s_p1, we_, wr_addr, wr_data,
                     v.cnt, v.rdy, v.p0, v.p1, v.we, v.wa, v.wd);
        end else begin
            $display("vec%0d ok: cnt=%0d rdy=%b p0=%b p1=%b we_=%b wa=%0d wd=%h",
                     idx, s_cnt, s_rdy, s_p0, s_p1, we_, wr_addr, wr_data);
        end
    endtask

    initial begin
        reset = 1'b1;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        chk_addr_0 = '0; chk_addr_1 = '0;
        repeat (2) @(posedge clk);

        //           rst ldv lda ldd     av aa ad      c0 c1  cnt rdy p0 p1  we wa  wd
        // reset state
        tbl.push_back(mk(1, 0, 0, 0,      0, 0, 0,      0, 0,  0, 1, 0, 0,  1, 0, 0));
        // ALU only, empty buffer: direct write
        tbl.push_back(mk(0, 0, 0, 0,      1, 3, 'h11,   3, 0,  0, 1, 0, 0,  0, 3, 'h11));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      3, 0,  0, 1, 0, 0,  1, 3, 'h11));
        // same-cycle load and ALU to r5: load first, ALU next
        tbl.push_back(mk(0, 1, 5, 'hAA,   1, 5, 'hBB,   5, 5,  0, 1, 0, 0,  0, 5, 'hAA));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      5, 5,  1, 1, 1, 1,  0, 5, 'hBB));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      5, 5,  0, 1, 0, 0,  1, 5, 'hBB));
        // fill: four loads while r1,r2,r3 offered; r3 waits for space
        tbl.push_back(mk(0, 1, 10, 'h100, 1, 1, 'h201,  1, 2,  0, 1, 0, 0,  0, 10, 'h100));
        tbl.push_back(mk(0, 1, 11, 'h101, 1, 2, 'h202,  1, 2,  1, 1, 1, 0,  0, 11, 'h101));
        tbl.push_back(mk(0, 1, 12, 'h102, 1, 3, 'h203,  1, 2,  2, 0, 1, 1,  0, 12, 'h102));
        tbl.push_back(mk(0, 1, 13, 'h103, 1, 3, 'h203,  1, 2,  2, 0, 1, 1,  0, 13, 'h103));
        tbl.push_back(mk(0, 0, 0, 0,      1, 3, 'h203,  1, 2,  2, 0, 1, 1,  0, 1, 'h201));
        tbl.push_back(mk(0, 0, 0, 0,      1, 3, 'h203,  1, 2,  1, 1, 0, 1,  0, 2, 'h202));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      3, 2,  1, 1, 1, 0,  0, 3, 'h203));
        // push and pop together: r7 buffered, r8 offered
        tbl.push_back(mk(0, 1, 20, 'h300, 1, 7, 'h77,   7, 8,  0, 1, 0, 0,  0, 20, 'h300));
        tbl.push_back(mk(0, 0, 0, 0,      1, 8, 'h88,   7, 8,  1, 1, 1, 0,  0, 7, 'h77));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      7, 8,  1, 1, 0, 1,  0, 8, 'h88));
        // idle after r9=5: port holds
        tbl.push_back(mk(0, 0, 0, 0,      1, 9, 'h5,    9, 0,  0, 1, 0, 0,  0, 9, 'h5));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      9, 0,  0, 1, 0, 0,  1, 9, 'h5));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      9, 0,  0, 1, 0, 0,  1, 9, 'h5));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      9, 0,  0, 1, 0, 0,  1, 9, 'h5));
        // full-width data passes unchanged
        tbl.push_back(mk(0, 1, 31, 'hFFFFFFFF, 0, 0, 0, 0, 0,  0, 1, 0, 0,  0, 31, 'hFFFFFFFF));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      0, 0,  0, 1, 0, 0,  1, 31, 'hFFFFFFFF));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], i);

        // multi-cycle: fill both entries, reset with live inputs, confirm nothing leaks out
        tbl.delete();
        tbl.push_back(mk(0, 1, 1, 'h1,    1, 2, 'h2,    2, 4,  0, 1, 0, 0,  0, 1, 'h1));
        tbl.push_back(mk(0, 1, 3, 'h3,    1, 4, 'h4,    2, 4,  1, 1, 1, 0,  0, 3, 'h3));
        tbl.push_back(mk(1, 1, 5, 'h5,    1, 6, 'h6,    2, 4,  2, 0, 1, 1,  1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      2, 4,  0, 1, 0, 0,  1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      6, 5,  0, 1, 0, 0,  1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,      1, 6, 'h66,   6, 4,  0, 1, 0, 0,  0, 6, 'h66));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], 100 + i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The module SHALL have parameters: DATA_W, 32, register data width; ADDR_W, 5, register address width; DEPTH, 2, ALU result buffer entries.
REQ-002 The module SHALL have ports: clk  in  1  clock, all state updates on rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 ld_valid  in  1  load result valid; always accepted, no ready.
REQ-005 ld_addr  in  ADDR_W  load destination register; ld_data  in  DATA_W  load data.
REQ-006 alu_valid  in  1  ALU result valid; alu_addr  in  ADDR_W; alu_data  in  DATA_W.
REQ-007 alu_ready  out  1  ALU result accepted when alu_valid && alu_ready.
REQ-008 we_  out  1  register file write enable, active-low, registered.
REQ-009 wr_addr  out  ADDR_W  and  wr_data  out  DATA_W  register file write address/data, registered.
REQ-010 chk_addr_0, chk_addr_1  in  ADDR_W  decode-stage source register addresses.
REQ-011 pend_0, pend_1  out  1  chk_addr_n matches a valid buffered ALU entry.
REQ-012 buf_cnt  out  2  number of valid buffer entries, 0..DEPTH.

Function
REQ-013 At most one register write SHALL be issued per cycle; source priority: ld input > buffer head > direct ALU input.
REQ-014 alu_ready SHALL equal (buf_cnt < DEPTH), derived only from registered state.
REQ-015 Load accepted in cycle t SHALL produce we_=0, wr_addr=ld_addr, wr_data=ld_data in cycle t+1.
REQ-016 Accepted ALU result with ld_valid=0 and buf_cnt=0 SHALL bypass the buffer, appearing on write port at t+1.
REQ-017 Accepted ALU result SHALL be pushed to the buffer tail when ld_valid=1 or buf_cnt>0.
REQ-018 With ld_valid=0 and buf_cnt>0, the head entry SHALL be popped and written at t+1.
REQ-019 Push and pop in the same cycle SHALL be allowed; buf_cnt unchanged; entries leave in push order.
REQ-020 Writes SHALL reach the port in acceptance order; in same-cycle ld+ALU acceptance the load is written first.
REQ-021 Cycle with no write source SHALL drive we_=1 at t+1; wr_addr/wr_data hold previous values.
REQ-022 pend_n SHALL be combinational over valid buffer entries only; entry being popped this cycle still counts.
REQ-023 Buffer full with ld_valid=1 for consecutive cycles: buffer SHALL hold, alu_ready=0, no entry lost or reordered.
REQ-024 Buffer pointers SHALL wrap modulo DEPTH; buf_cnt SHALL never exceed DEPTH nor underflow.
REQ-025 Write data SHALL pass unmodified, full DATA_W, no sign or width change.

Reset
REQ-026 reset=1 at a rising edge SHALL set we_=1, wr_addr=0, wr_data=0, buf_cnt=0, all entry valids 0.
REQ-027 During reset alu_ready SHALL be 1 after the first reset edge; inputs presented while reset=1 SHALL be discarded.
REQ-028 Reset mid-operation SHALL drop all buffered entries; no write issued in cycle after reset edge.

Verification
REQ-029 ALU only: alu r3=0x11 at t, buf empty -> we_=0, wr_addr=3, wr_data=0x11 at t+1; buf_cnt stays 0.
REQ-030 Same cycle: ld r5=0xAA, alu r5=0xBB -> t+1 write r5=0xAA, t+2 write r5=0xBB; pend_0 for chk_addr_0=5 high in t+1 only.
REQ-031 Fill: ld_valid=1 for 4 cycles with alu r1,r2,r3 offered each cycle -> buf_cnt 1,2,2, alu_ready low when 2; after loads end, r1 then r2 then r3 written in order.
REQ-032 Push+pop: buf_cnt=1 (r7), alu r8 offered, ld_valid=0 -> r7 written, r8 buffered, buf_cnt stays 1, then r8 written.
REQ-033 Reset with buf_cnt=2 -> next cycle we_=1, buf_cnt=0, pend_0/pend_1=0, alu_ready=1; buffered writes never appear.
REQ-034 Idle: no valids for 3 cycles after a write of r9=0x5 -> we_=1, wr_addr=9, wr_data=0x5 held.
